// File: rtl/id_stage_p.sv
// id_stage_p: instruction-decode stage for the pipelined MIPS CPU.
//
// Decodes instr_d, reads the internal register file (with write-through
// bypass from writeback), resolves BEQ/BNE (and J/JAL/JR when enabled) in ID
// using forwarded compare operands, and drives the ID/EX pipeline register.
//
// Optional feature macro: ID_JUMP_EN
//   defined   -> J (op 02), JAL (op 03) and JR (funct 08) are decoded.
//   undefined -> those encodings flag illegal_d and decode as a NOP;
//                link_e never asserts.
//
// Ports
//   clk, reset               clock, asynchronous active-high reset
//   instr_d, pc_plus4_d      instruction in ID and its PC+4
//   valid_d                  instr_d is a real instruction
//   stall_d, flush_e         hold / bubble the ID/EX register (flush wins)
//   reg_write_w, write_reg_w, result_w   register file write port
//   fwd_a_d, fwd_b_d, alu_out_m          compare-operand forwarding
//   rs_d, rt_d               source fields to the hazard unit
//   pc_src_d, pc_target_d    fetch redirect request and address
//   illegal_d                unsupported encoding in ID
//   *_e                      ID/EX register outputs
module id_stage_p #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [31:0]               instr_d,
  input  logic [XLEN-1:0]           pc_plus4_d,
  input  logic                      valid_d,
  input  logic                      stall_d,
  input  logic                      flush_e,
  input  logic                      reg_write_w,
  input  logic [$clog2(NREGS)-1:0]  write_reg_w,
  input  logic [XLEN-1:0]           result_w,
  input  logic                      fwd_a_d,
  input  logic                      fwd_b_d,
  input  logic [XLEN-1:0]           alu_out_m,
  output logic [4:0]                rs_d,
  output logic [4:0]                rt_d,
  output logic                      pc_src_d,
  output logic [XLEN-1:0]           pc_target_d,
  output logic                      illegal_d,
  output logic                      valid_e,
  output logic                      reg_write_e,
  output logic                      mem_to_reg_e,
  output logic                      mem_write_e,
  output logic                      alu_src_e,
  output logic                      reg_dst_e,
  output logic                      link_e,
  output logic [2:0]                alu_ctrl_e,
  output logic [4:0]                rs_e,
  output logic [4:0]                rt_e,
  output logic [4:0]                rd_e,
  output logic [4:0]                shamt_e,
  output logic [XLEN-1:0]           rd1_e,
  output logic [XLEN-1:0]           rd2_e,
  output logic [XLEN-1:0]           imm_e,
  output logic [XLEN-1:0]           pc_plus4_e
);

  localparam int unsigned RW = $clog2(NREGS);
  // Specifier bits that must be zero for the configured register count.
  localparam logic [4:0] HiMask = 5'(5'h1f << RW);

  // ALU codes
  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSll = 3'b100;
  localparam logic [2:0] AluSrl = 3'b101;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluSlt = 3'b111;

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic            mem_to_reg;
    logic            mem_write;
    logic            alu_src;
    logic            reg_dst;
    logic            link;
    logic [2:0]      alu_ctrl;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [4:0]      shamt;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc_plus4;
  } idex_t;

  // ---------------------------------------------------------------------------
  // Instruction fields
  // ---------------------------------------------------------------------------
  logic [5:0]      op;
  logic [5:0]      funct;
  logic [4:0]      rd_f;
  logic [4:0]      shamt_f;
  logic [XLEN-1:0] imm_ext;

  assign op      = instr_d[31:26];
  assign funct   = instr_d[5:0];
  assign rs_d    = instr_d[25:21];
  assign rt_d    = instr_d[20:16];
  assign rd_f    = instr_d[15:11];
  assign shamt_f = instr_d[10:6];
  assign imm_ext = {{(XLEN-16){instr_d[15]}}, instr_d[15:0]};

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] regs_q [NREGS];
  logic [RW-1:0]   rs_idx;
  logic [RW-1:0]   rt_idx;
  logic            wr_en;
  logic [XLEN-1:0] rd1_v;
  logic [XLEN-1:0] rd2_v;

  assign rs_idx = rs_d[RW-1:0];
  assign rt_idx = rt_d[RW-1:0];
  assign wr_en  = reg_write_w && (write_reg_w != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[write_reg_w] <= result_w;
    end
  end

  // Write-through: a same-cycle write to the read index is returned directly.
  always_comb begin
    rd1_v = '0;
    rd2_v = '0;
    if (rs_idx != '0) begin
      rd1_v = (wr_en && (write_reg_w == rs_idx)) ? result_w : regs_q[rs_idx];
    end
    if (rt_idx != '0) begin
      rd2_v = (wr_en && (write_reg_w == rt_idx)) ? result_w : regs_q[rt_idx];
    end
  end

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic       known;
  logic       use_rs;
  logic       use_rt;
  logic       use_rd;
  logic       dec_reg_write;
  logic       dec_mem_to_reg;
  logic       dec_mem_write;
  logic       dec_alu_src;
  logic       dec_reg_dst;
  logic       dec_link;
  logic [2:0] dec_alu_ctrl;
  logic       is_beq;
  logic       is_bne;
  logic       is_j;
  logic       is_jr;

  always_comb begin
    known          = 1'b0;
    use_rs         = 1'b0;
    use_rt         = 1'b0;
    use_rd         = 1'b0;
    dec_reg_write  = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_mem_write  = 1'b0;
    dec_alu_src    = 1'b0;
    dec_reg_dst    = 1'b0;
    dec_link       = 1'b0;
    dec_alu_ctrl   = AluAnd;
    is_beq         = 1'b0;
    is_bne         = 1'b0;
    is_j           = 1'b0;
    is_jr          = 1'b0;
    unique case (op)
      6'h00: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
        use_rd = 1'b1;
        unique case (funct)
          6'h00: begin known = 1'b1; dec_alu_ctrl = AluSll; end
          6'h02: begin known = 1'b1; dec_alu_ctrl = AluSrl; end
          6'h20: begin known = 1'b1; dec_alu_ctrl = AluAdd; end
          6'h22: begin known = 1'b1; dec_alu_ctrl = AluSub; end
          6'h24: begin known = 1'b1; dec_alu_ctrl = AluAnd; end
          6'h25: begin known = 1'b1; dec_alu_ctrl = AluOr;  end
          6'h2a: begin known = 1'b1; dec_alu_ctrl = AluSlt; end
`ifdef ID_JUMP_EN
          6'h08: begin
            known  = 1'b1;
            is_jr  = 1'b1;
            use_rt = 1'b0;
            use_rd = 1'b0;
          end
`endif
          default: known = 1'b0;
        endcase
        if (known && !is_jr) begin
          dec_reg_write = 1'b1;
          dec_reg_dst   = 1'b1;
        end
      end
      6'h08, 6'h23: begin // ADDI, LW
        known          = 1'b1;
        use_rs         = 1'b1;
        use_rt         = 1'b1;
        dec_reg_write  = 1'b1;
        dec_alu_src    = 1'b1;
        dec_mem_to_reg = (op == 6'h23);
        dec_alu_ctrl   = AluAdd;
      end
      6'h2b: begin // SW
        known         = 1'b1;
        use_rs        = 1'b1;
        use_rt        = 1'b1;
        dec_mem_write = 1'b1;
        dec_alu_src   = 1'b1;
        dec_alu_ctrl  = AluAdd;
      end
      6'h04, 6'h05: begin // BEQ, BNE
        known        = 1'b1;
        use_rs       = 1'b1;
        use_rt       = 1'b1;
        is_beq       = (op == 6'h04);
        is_bne       = (op == 6'h05);
        dec_alu_ctrl = AluSub;
      end
`ifdef ID_JUMP_EN
      6'h02, 6'h03: begin // J, JAL
        known = 1'b1;
        is_j  = 1'b1;
        if (op == 6'h03) begin
          dec_reg_write = 1'b1;
          dec_reg_dst   = 1'b1;
          dec_link      = 1'b1;
        end
      end
`endif
      default: known = 1'b0;
    endcase
  end

  // A used specifier naming a register beyond NREGS is illegal.
  logic bad_spec;
  logic ctl_ok;

  assign bad_spec = (use_rs && ((rs_d & HiMask) != '0)) ||
                    (use_rt && ((rt_d & HiMask) != '0)) ||
                    (use_rd && ((rd_f & HiMask) != '0));
  // Bubbles (valid_d=0) are never flagged illegal.
  assign illegal_d = valid_d && (!known || bad_spec);
  assign ctl_ok    = valid_d && known && !bad_spec;

  // ---------------------------------------------------------------------------
  // Branch / jump resolution
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] cmp_a;
  logic [XLEN-1:0] cmp_b;
  logic            cmp_eq;
  logic [XLEN-1:0] br_target;

  assign cmp_a     = fwd_a_d ? alu_out_m : rd1_v;
  assign cmp_b     = fwd_b_d ? alu_out_m : rd2_v;
  assign cmp_eq    = (cmp_a == cmp_b);
  assign br_target = pc_plus4_d + (imm_ext << 2);

  assign pc_src_d = ctl_ok && ((is_beq && cmp_eq) || (is_bne && !cmp_eq) || is_j || is_jr);

`ifdef ID_JUMP_EN
  logic [XLEN-1:0] j_target;
  assign j_target = {pc_plus4_d[XLEN-1:28], instr_d[25:0], 2'b00};

  always_comb begin
    pc_target_d = br_target;
    if (is_jr) begin
      pc_target_d = cmp_a;
    end else if (is_j) begin
      pc_target_d = j_target;
    end
  end
`else
  assign pc_target_d = br_target;
`endif

  // ---------------------------------------------------------------------------
  // ID/EX register
  // ---------------------------------------------------------------------------
  idex_t idex_load;
  idex_t idex_d;
  idex_t idex_q;

  always_comb begin
    idex_load            = '0;
    idex_load.valid      = valid_d;
    idex_load.reg_write  = dec_reg_write & ctl_ok;
    idex_load.mem_to_reg = dec_mem_to_reg & ctl_ok;
    idex_load.mem_write  = dec_mem_write & ctl_ok;
    idex_load.alu_src    = dec_alu_src & ctl_ok;
    idex_load.reg_dst    = dec_reg_dst & ctl_ok;
    idex_load.link       = dec_link & ctl_ok;
    idex_load.alu_ctrl   = ctl_ok ? dec_alu_ctrl : AluAnd;
    idex_load.rs         = rs_d;
    idex_load.rt         = rt_d;
    // JAL writes its return address to r31.
    idex_load.rd         = (dec_link && ctl_ok) ? 5'd31 : rd_f;
    idex_load.shamt      = shamt_f;
    idex_load.rd1        = rd1_v;
    idex_load.rd2        = rd2_v;
    idex_load.imm        = imm_ext;
    idex_load.pc_plus4   = pc_plus4_d;
  end

  always_comb begin
    idex_d = idex_q;
    if (flush_e) begin
      idex_d = '0;
    end else if (!stall_d) begin
      idex_d = idex_load;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  assign valid_e      = idex_q.valid;
  assign reg_write_e  = idex_q.reg_write;
  assign mem_to_reg_e = idex_q.mem_to_reg;
  assign mem_write_e  = idex_q.mem_write;
  assign alu_src_e    = idex_q.alu_src;
  assign reg_dst_e    = idex_q.reg_dst;
  assign link_e       = idex_q.link;
  assign alu_ctrl_e   = idex_q.alu_ctrl;
  assign rs_e         = idex_q.rs;
  assign rt_e         = idex_q.rt;
  assign rd_e         = idex_q.rd;
  assign shamt_e      = idex_q.shamt;
  assign rd1_e        = idex_q.rd1;
  assign rd2_e        = idex_q.rd2;
  assign imm_e        = idex_q.imm;
  assign pc_plus4_e   = idex_q.pc_plus4;

endmodule

// File: tb/tb_id_stage_p.sv
module tb_id_stage_p;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instr_d = '0;
  logic [31:0] pc_plus4_d = '0;
  logic        valid_d = 1'b0;
  logic        stall_d = 1'b0;
  logic        flush_e = 1'b0;
  logic        reg_write_w = 1'b0;
  logic [4:0]  write_reg_w = '0;
  logic [31:0] result_w = '0;
  logic        fwd_a_d = 1'b0;
  logic        fwd_b_d = 1'b0;
  logic [31:0] alu_out_m = '0;
  logic [4:0]  rs_d, rt_d;
  logic        pc_src_d, illegal_d;
  logic [31:0] pc_target_d;
  logic        valid_e, reg_write_e, mem_to_reg_e, mem_write_e, alu_src_e, reg_dst_e, link_e;
  logic [2:0]  alu_ctrl_e;
  logic [4:0]  rs_e, rt_e, rd_e, shamt_e;
  logic [31:0] rd1_e, rd2_e, imm_e, pc_plus4_e;
  logic [9:0]  ctl_e;

  always #5 clk = ~clk;

  id_stage_p #(.XLEN(32), .NREGS(32)) dut (
    .clk(clk), .reset(reset), .instr_d(instr_d), .pc_plus4_d(pc_plus4_d),
    .valid_d(valid_d), .stall_d(stall_d), .flush_e(flush_e),
    .reg_write_w(reg_write_w), .write_reg_w(write_reg_w), .result_w(result_w),
    .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d), .alu_out_m(alu_out_m),
    .rs_d(rs_d), .rt_d(rt_d), .pc_src_d(pc_src_d), .pc_target_d(pc_target_d),
    .illegal_d(illegal_d), .valid_e(valid_e), .reg_write_e(reg_write_e),
    .mem_to_reg_e(mem_to_reg_e), .mem_write_e(mem_write_e), .alu_src_e(alu_src_e),
    .reg_dst_e(reg_dst_e), .link_e(link_e), .alu_ctrl_e(alu_ctrl_e),
    .rs_e(rs_e), .rt_e(rt_e), .rd_e(rd_e), .shamt_e(shamt_e),
    .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_e(imm_e), .pc_plus4_e(pc_plus4_e)
  );

  // {valid, reg_write, mem_to_reg, mem_write, alu_src, reg_dst, link, alu_ctrl}
  assign ctl_e = {valid_e, reg_write_e, mem_to_reg_e, mem_write_e, alu_src_e, reg_dst_e,
                  link_e, alu_ctrl_e};

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        fa;
    logic        fb;
    logic [31:0] aluout;
    logic        pc_src;
    logic [31:0] target;
    logic        illegal;
    logic [9:0]  ctl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
  } vec_t;

  localparam int NV = 18;
  vec_t vt [NV];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc4, input logic v,
                       input logic fa, input logic fb, input logic [31:0] am);
    instr_d    = ins;
    pc_plus4_d = pc4;
    valid_d    = v;
    fwd_a_d    = fa;
    fwd_b_d    = fb;
    alu_out_m  = am;
  endtask

  task automatic wb(input logic en, input logic [4:0] idx, input logic [31:0] data);
    reg_write_w = en;
    write_reg_w = idx;
    result_w    = data;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {22'd0, ctl_e}, 32'd0);
    chk({tag, "_fields"}, {12'd0, rs_e, rt_e, rd_e, shamt_e}, 32'd0);
    chk({tag, "_rd1"}, rd1_e, 32'd0);
    chk({tag, "_rd2"}, rd2_e, 32'd0);
    chk({tag, "_imm"}, imm_e, 32'd0);
    chk({tag, "_pc4"}, pc_plus4_e, 32'd0);
  endtask

  initial begin
    // instr, pc4, valid, fa, fb, aluout, pc_src, target, illegal, ctl, rd1, rd2, imm
    vt[0]  = '{32'h00222020, 32'h100, 1, 0, 0, 0, 0, 0, 0, 10'b1_1_0_0_0_1_0_010,
               5, 7, 32'h2020};                                   // ADD r4,r1,r2
    vt[1]  = '{32'h00412822, 32'h100, 1, 0, 0, 0, 0, 0, 0, 10'b1_1_0_0_0_1_0_110,
               7, 5, 32'h2822};                                   // SUB r5,r2,r1
    vt[2]  = '{32'h0022302A, 32'h100, 1, 0, 0, 0, 0, 0, 0, 10'b1_1_0_0_0_1_0_111,
               5, 7, 32'h302A};                                   // SLT r6,r1,r2
    vt[3]  = '{32'h2027FFFC, 32'h100, 1, 0, 0, 0, 0, 0, 0, 10'b1_1_0_0_1_0_0_010,
               5, 0, 32'hFFFFFFFC};                               // ADDI r7,r1,-4
    vt[4]  = '{32'h8C480010, 32'h100, 1, 0, 0, 0, 0, 0, 0, 10'b1_1_1_0_1_0_0_010,
               7, 0, 32'h10};                                     // LW r8,16(r2)
    vt[5]  = '{32'hAC410008, 32'h100, 1, 0, 0, 0, 0, 0, 0, 10'b1_0_0_1_1_0_0_010,
               7, 5, 32'h8};                                      // SW r1,8(r2)
    vt[6]  = '{32'h10210002, 32'h100, 1, 0, 0, 0, 1, 32'h108, 0, 10'b1_0_0_0_0_0_0_110,
               5, 5, 32'h2};                                      // BEQ r1,r1 taken
    vt[7]  = '{32'h1022FFFF, 32'h100, 1, 0, 0, 0, 0, 0, 0, 10'b1_0_0_0_0_0_0_110,
               5, 7, 32'hFFFFFFFF};                               // BEQ r1,r2 not taken
    vt[8]  = '{32'h14220004, 32'h00400004, 1, 0, 1, 5, 0, 0, 0, 10'b1_0_0_0_0_0_0_110,
               5, 7, 32'h4};                                      // BNE fwd b=5 equal
    vt[9]  = '{32'h14220004, 32'h00400004, 1, 0, 1, 6, 1, 32'h00400014, 0,
               10'b1_0_0_0_0_0_0_110, 5, 7, 32'h4};               // BNE fwd b=6 taken
    vt[10] = '{32'h1422FFFC, 32'h4, 1, 0, 0, 0, 1, 32'hFFFFFFF4, 0,
               10'b1_0_0_0_0_0_0_110, 5, 7, 32'hFFFFFFFC};        // BNE target wraps
    vt[11] = '{32'hFC000000, 32'h100, 1, 0, 0, 0, 0, 0, 1, 10'b1_0_0_0_0_0_0_000,
               0, 0, 32'h0};                                      // opcode 0x3F
    vt[12] = '{32'h10210002, 32'h100, 0, 0, 0, 0, 0, 0, 0, 10'b0_0_0_0_0_0_0_000,
               5, 5, 32'h2};                                      // valid_d=0
    vt[13] = '{32'h00222001, 32'h100, 1, 0, 0, 0, 0, 0, 1, 10'b1_0_0_0_0_0_0_000,
               5, 7, 32'h2001};                                   // bad funct 01
    vt[14] = '{32'h000220C0, 32'h100, 1, 0, 0, 0, 0, 0, 0, 10'b1_1_0_0_0_1_0_100,
               0, 7, 32'h20C0};                                   // SLL r4,r2,3
`ifdef ID_JUMP_EN
    vt[15] = '{32'h00200008, 32'h100, 1, 0, 0, 0, 1, 32'h5, 0, 10'b1_0_0_0_0_0_0_000,
               5, 0, 32'h8};                                      // JR r1
    vt[16] = '{32'h0C000100, 32'h00400004, 1, 0, 0, 0, 1, 32'h00000400, 0,
               10'b1_1_0_0_0_1_1_000, 0, 0, 32'h100};             // JAL
    vt[17] = '{32'h0BFFFFFF, 32'hA0000000, 1, 0, 0, 0, 1, 32'hAFFFFFFC, 0,
               10'b1_0_0_0_0_0_0_000, 0, 0, 32'hFFFFFFFF};        // J
`else
    vt[15] = '{32'h00200008, 32'h100, 1, 0, 0, 0, 0, 0, 1, 10'b1_0_0_0_0_0_0_000,
               5, 0, 32'h8};
    vt[16] = '{32'h0C000100, 32'h00400004, 1, 0, 0, 0, 0, 0, 1, 10'b1_0_0_0_0_0_0_000,
               0, 0, 32'h100};
    vt[17] = '{32'h0BFFFFFF, 32'hA0000000, 1, 0, 0, 0, 0, 0, 1, 10'b1_0_0_0_0_0_0_000,
               0, 0, 32'hFFFFFFFF};
`endif

    // Asynchronous reset before any clock edge.
    #2 reset = 1'b1;
    #1 chk_all_zero("reset_async");
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    // Preload r1=5, r2=7, r5=0x55.
    wb(1, 5'd1, 32'd5);
    @(negedge clk) wb(1, 5'd2, 32'd7);
    @(negedge clk) wb(1, 5'd5, 32'h55);

    // Write r3 in the same cycle as ADD r4,r3,r0 reads it.
    @(negedge clk);
    wb(1, 5'd3, 32'h1234);
    drive(32'h00602020, 32'h200, 1, 0, 0, 0);
    #1;
    chk("rs_d", {27'd0, rs_d}, 32'd3);
    chk("rt_d", {27'd0, rt_d}, 32'd0);
    @(posedge clk); #1;
    chk("bypass_rd1", rd1_e, 32'h1234);
    chk("bypass_ctl", {22'd0, ctl_e}, {22'd0, 10'b1_1_0_0_0_1_0_010});
    chk("bypass_pc4", pc_plus4_e, 32'h200);

    // Writes to r0 are ignored, including the bypass path.
    @(negedge clk);
    wb(1, 5'd0, 32'hDEAD);
    drive(32'h00012020, 32'h200, 1, 0, 0, 0);   // ADD r4,r0,r1
    @(posedge clk); #1;
    chk("r0_bypass_rd1", rd1_e, 32'd0);
    chk("r0_bypass_rd2", rd2_e, 32'd5);
    @(negedge clk) wb(0, 5'd0, 32'd0);
    @(posedge clk); #1;
    chk("r0_stays_zero", rd1_e, 32'd0);

    // Table-driven vectors.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vt[i].instr, vt[i].pc4, vt[i].valid, vt[i].fa, vt[i].fb, vt[i].aluout);
      #1;
      chk($sformatf("v%0d_pc_src", i), {31'd0, pc_src_d}, {31'd0, vt[i].pc_src});
      chk($sformatf("v%0d_illegal", i), {31'd0, illegal_d}, {31'd0, vt[i].illegal});
      if (vt[i].pc_src) chk($sformatf("v%0d_target", i), pc_target_d, vt[i].target);
      @(posedge clk); #1;
      chk($sformatf("v%0d_ctl", i), {22'd0, ctl_e}, {22'd0, vt[i].ctl});
      chk($sformatf("v%0d_rd1", i), rd1_e, vt[i].rd1);
      chk($sformatf("v%0d_rd2", i), rd2_e, vt[i].rd2);
      chk($sformatf("v%0d_imm", i), imm_e, vt[i].imm);
      chk($sformatf("v%0d_pc4", i), pc_plus4_e, vt[i].pc4);
    end

    // Field routing: SLL shamt/rd, then JAL destination.
    @(negedge clk) drive(32'h000220C0, 32'h100, 1, 0, 0, 0);
    @(posedge clk); #1;
    chk("sll_shamt", {27'd0, shamt_e}, 32'd3);
    chk("sll_rd", {27'd0, rd_e}, 32'd4);
    chk("sll_rt", {27'd0, rt_e}, 32'd2);
    @(negedge clk) drive(32'h0C000100, 32'h00400004, 1, 0, 0, 0);
    @(posedge clk); #1;
`ifdef ID_JUMP_EN
    chk("jal_rd", {27'd0, rd_e}, 32'd31);
`else
    chk("jal_rd", {27'd0, rd_e}, 32'd0);
`endif

    // Stall holds a loaded LW; flush with stall gives a bubble.
    @(negedge clk) drive(32'h8C480010, 32'h100, 1, 0, 0, 0);
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      stall_d = 1'b1;
      drive(32'h00222020, 32'h300, 1, 0, 0, 0);
      @(posedge clk); #1;
      chk($sformatf("stall%0d_ctl", k), {22'd0, ctl_e}, {22'd0, 10'b1_1_1_0_1_0_0_010});
      chk($sformatf("stall%0d_imm", k), imm_e, 32'h10);
      chk($sformatf("stall%0d_rd1", k), rd1_e, 32'd7);
      chk($sformatf("stall%0d_pc4", k), pc_plus4_e, 32'h100);
    end
    @(negedge clk) flush_e = 1'b1;
    @(posedge clk); #1;
    chk_all_zero("flush_stall");
    @(negedge clk);
    flush_e = 1'b0;
    stall_d = 1'b0;

    // Mid-cycle reset clears ID/EX immediately and the register file.
    drive(32'h00A03020, 32'h400, 1, 0, 0, 0);      // ADD r6,r5,r0
    @(posedge clk); #1;
    chk("pre_reset_rd1", rd1_e, 32'h55);
    #2 reset = 1'b1;
    #1 chk_all_zero("reset_mid");
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_r5", rd1_e, 32'd0);
    chk("post_reset_ctl", {22'd0, ctl_e}, {22'd0, 10'b1_1_0_0_0_1_0_010});

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/id_stage_p.md
# id_stage_p

Parametrised instruction-decode stage for the pipelined MIPS CPU, sitting between the IF/ID register and the execute stage. It decodes the instruction, reads the internal register file with write-through bypass, and resolves branches and jumps early in ID using forwarded operands. It drives the ID/EX pipeline register with stall-hold, flush-bubble and a valid bit. Compared with the first-generation decode stage, it adds a width/depth-parametrised register file, reset, stall, a valid bit, BNE/JR/J/JAL resolution in ID, and illegal-opcode flagging.

## Interface
- XLEN, 32, datapath width; must be ≥ 32.
- NREGS, 32, register count; legal values are 8, 16 or 32. RW = log2(NREGS).

- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears every register in the block.
- instr_d  in  32  instruction in ID.
- pc_plus4_d  in  XLEN  PC+4 of instr_d.
- valid_d  in  1  instr_d is a real instruction.
- stall_d  in  1  hold the ID/EX register.
- flush_e  in  1  load a bubble into ID/EX; wins over stall_d.
- reg_write_w  in  1  writeback enable.
- write_reg_w  in  RW  writeback register index.
- result_w  in  XLEN  writeback data.
- fwd_a_d, fwd_b_d  in  1  select alu_out_m for the rs/rt compare operand.
- alu_out_m  in  XLEN  MEM-stage ALU result.
- rs_d, rt_d  out  5  instr_d[25:21], instr_d[20:16] (to the hazard unit).
- pc_src_d  out  1  redirect fetch this cycle.
- pc_target_d  out  XLEN  redirect address.
- illegal_d  out  1  unsupported encoding in ID.
- valid_e, reg_write_e, mem_to_reg_e, mem_write_e, alu_src_e, reg_dst_e, link_e  out  1 each  EX controls.
- alu_ctrl_e  out  3  ALU code.
- rs_e, rt_e, rd_e, shamt_e  out  5 each  EX register fields.
- rd1_e, rd2_e, imm_e, pc_plus4_e  out  XLEN each  EX operands.

## Operation

**Register file**
- r0 reads as 0 and is never written.
- Write on the clk edge when reg_write_w=1 and write_reg_w≠0.
- Reads are combinational. A read of the index being written in the same cycle returns result_w (write-through).
- Register specifier bits above RW must be zero; otherwise illegal_d=1.

**Decode**
- ALU codes: AND=000, OR=001, ADD/ADDI/LW/SW=010, SLL=100, SRL=101, SUB/BEQ/BNE=110, SLT=111.
- R-type (op 0): funct 00/02/20/22/24/25/2A → reg_write=1, reg_dst=1, alu_src=0. funct 08 → JR.
- ADDI (08) and LW (23): reg_write=1, alu_src=1, reg_dst=0. LW also sets mem_to_reg=1.
- SW (2B): mem_write=1, alu_src=1.
- BEQ (04), BNE (05): no write.
- imm_e is the sign-extension of instr[15:0] to XLEN.
- Any other encoding: illegal_d=1 and all enables are 0 (NOP), but the instruction still occupies the slot with valid_e=1.

**Branch resolution (combinational)**
- a = fwd_a_d ? alu_out_m : rd1; b = fwd_b_d ? alu_out_m : rd2.
- pc_src_d = valid_d & ((BEQ & a==b) | (BNE & a≠b) | jump).
- Branch target = pc_plus4_d + (sext(imm)<<2), modulo 2^XLEN.

**ID/EX register**
- Priority on the edge: reset, then flush_e (bubble: every output 0), then stall_d (hold), then load.

## Timing
- Reset value of every registered output is 0. Reset also clears all NREGS registers. Reset asserted mid-operation clears immediately, without waiting for clk.
- Decode, illegal_d, pc_src_d and pc_target_d are valid in the same cycle as instr_d.
- ID/EX outputs appear 1 cycle after load.
- Register write in cycle N is visible to an ID read in cycle N through the bypass.
- flush_e and stall_d together produce a bubble.
- valid_d=0 produces pc_src_d=0, and a loaded valid_e=0 with all enables 0.

## Configuration
- ID_JUMP_EN defined: J (op 02), JAL (op 03) and JR are supported.
  - J/JAL target = {pc_plus4_d[XLEN-1:28], instr[25:0], 2'b00}; upper bits above 32 come from pc_plus4_d.
  - JR target = forwarded a.
  - JAL sets reg_write_e=1, reg_dst_e=1, rd_e=31 and link_e=1; EX then writes pc_plus4_e.
- ID_JUMP_EN undefined: J, JAL and JR decode as illegal (illegal_d=1, NOP), and link_e is constant 0.

## Test plan
- Reset asserted asynchronously mid-cycle → all ID/EX outputs 0 immediately; a subsequent read of r5 returns 0.
- Writeback r3=0x1234 with instr ADD r4,r3,r0 in the same cycle → rd1_e=0x1234, alu_ctrl_e=010, reg_write_e=1 next cycle.
- BNE r1,r2,+4 with r1=5, fwd_b_d=1, alu_out_m=5 → pc_src_d=0. With alu_out_m=6 → pc_src_d=1, pc_target_d=pc_plus4_d+16.
- Load LW, then stall_d=1 for 2 cycles with a new instr_d → outputs hold LW values. flush_e=1 together with stall_d=1 → bubble (all 0).
- ID_JUMP_EN on: JAL 0x0000100 at pc_plus4=0x00400004 → pc_target_d=0x00000400, rd_e=31, link_e=1. With the macro off → illegal_d=1, pc_src_d=0.
- Opcode 0x3F → illegal_d=1, next-cycle valid_e=1 with reg_write_e=0 and mem_write_e=0.
